// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
// Optional BTB is enabled with the PC_GEN_BTB_EN macro (see pc_gen.sv).
package pc_gen_pkg;

  localparam int XLEN_DEF = 32;
  localparam int STEP_DEF = 4;
  // Width of a redirect channel index; supports up to 16 channels.
  localparam int IDX_W    = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  // A redirect as seen by the FSM: live selection or latched pending entry.
  // The target width is the package default; pc_gen is built with XLEN equal to it.
  typedef struct packed {
    logic                valid;
    logic [IDX_W-1:0]    idx;
    logic [XLEN_DEF-1:0] target;
  } redir_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bus of the PC generator: stall/redirect inputs, PC outputs,
// BTB update port. master = pipeline control, slave = pc_gen.
//
// Handshake: there is no valid/ready pair here. stall_i is a level that
// freezes pc_o; redir_valid_i[k] is a single-cycle request that is either
// applied (unstalled) or latched (stalled) on the edge it is seen, so the
// source never needs to hold it. pc_o is meaningful only while pc_valid_o=1.
interface pc_gen_if #(
  parameter int XLEN      = pc_gen_pkg::XLEN_DEF,
  parameter int NUM_REDIR = 2
);
  logic                      stall_i;
  logic [NUM_REDIR-1:0]      redir_valid_i;
  logic [NUM_REDIR*XLEN-1:0] redir_target_i;
  logic [XLEN-1:0]           pc_o;
  logic                      pc_valid_o;
  logic                      redir_pend_o;
  logic                      misalign_o;
  logic                      btb_upd_valid_i;
  logic [XLEN-1:0]           btb_upd_pc_i;
  logic [XLEN-1:0]           btb_upd_target_i;
  logic                      pred_taken_o;

  modport master (
    output stall_i, redir_valid_i, redir_target_i,
    output btb_upd_valid_i, btb_upd_pc_i, btb_upd_target_i,
    input  pc_o, pc_valid_o, redir_pend_o, misalign_o, pred_taken_o
  );

  modport slave (
    input  stall_i, redir_valid_i, redir_target_i,
    input  btb_upd_valid_i, btb_upd_pc_i, btb_upd_target_i,
    output pc_o, pc_valid_o, redir_pend_o, misalign_o, pred_taken_o
  );
endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer. Combinational lookup, synchronous
// write; a write and a lookup of the same entry in one cycle sees old data.
// Addresses arrive with the always-zero low log2(STEP) bits already dropped.
module pc_gen_btb #(
  parameter int XLEN  = 32,
  parameter int STEP  = 4,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [XLEN-$clog2(STEP)-1:0] look_addr_i,
  output logic                         hit_o,
  output logic [XLEN-1:0]              target_o,
  input  logic                         upd_valid_i,
  input  logic [XLEN-$clog2(STEP)-1:0] upd_addr_i,
  input  logic [XLEN-1:0]              upd_target_i
);

  localparam int AW = XLEN - $clog2(STEP);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = AW - IW;

  logic [DEPTH-1:0] valid_q;
  logic [TW-1:0]    tag_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];

  logic [IW-1:0] look_idx;
  logic [TW-1:0] look_tag;
  logic [IW-1:0] upd_idx;
  logic [TW-1:0] upd_tag;

  assign look_idx = look_addr_i[IW-1:0];
  assign look_tag = look_addr_i[AW-1:IW];
  assign upd_idx  = upd_addr_i[IW-1:0];
  assign upd_tag  = upd_addr_i[AW-1:IW];

  // Valid bits: cleared by reset, set by an update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (upd_valid_i) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset; the valid bit guards it.
  always_ff @(posedge clk) begin
    if (rst_n && upd_valid_i) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target_i;
    end
  end

  assign hit_o    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign target_o = tgt_q[look_idx];

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: prioritised redirects, stall-time redirect
// latching (RUN/HOLD FSM), sequential increment with wrap.
// Define PC_GEN_BTB_EN to add a direct-mapped BTB that steers sequential fetch.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              STEP      = STEP_DEF,
  parameter int              NUM_REDIR = 2,
  parameter int              BTB_DEPTH = 16
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave bus
);

  localparam int              OFF        = $clog2(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(STEP - 1);

  state_e          state_q, state_d;
  redir_t          pend_q, pend_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic            mis_q, mis_d;

  // Live redirect selection: highest channel index wins.
  redir_t live;
  always_comb begin
    live        = '0;
    live.target = bus.redir_target_i[0 +: XLEN];
    for (int k = 0; k < NUM_REDIR; k++) begin
      if (bus.redir_valid_i[k]) begin
        live.valid  = 1'b1;
        live.idx    = IDX_W'(k);
        live.target = bus.redir_target_i[k*XLEN +: XLEN];
      end
    end
  end

  logic            btb_hit;
  logic [XLEN-1:0] btb_tgt;

`ifdef PC_GEN_BTB_EN
  pc_gen_btb #(
    .XLEN (XLEN),
    .STEP (STEP),
    .DEPTH(BTB_DEPTH)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .look_addr_i (pc_q[XLEN-1:OFF]),
    .hit_o       (btb_hit),
    .target_o    (btb_tgt),
    .upd_valid_i (bus.btb_upd_valid_i),
    .upd_addr_i  (bus.btb_upd_pc_i[XLEN-1:OFF]),
    .upd_target_i(bus.btb_upd_target_i)
  );
  logic unused_upd_lo;
  assign unused_upd_lo = ^bus.btb_upd_pc_i[OFF-1:0];
`else
  assign btb_hit = 1'b0;
  assign btb_tgt = '0;
  logic unused_btb;
  assign unused_btb = ^{bus.btb_upd_valid_i, bus.btb_upd_pc_i, bus.btb_upd_target_i};
`endif

  // Next-state: FSM transitions, pending latch, PC source choice, misalign flag.
  logic            load;
  logic [XLEN-1:0] load_tgt;
  logic            live_wins;
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pc_d      = pc_q;
    mis_d     = 1'b0;
    load      = 1'b0;
    load_tgt  = live.target;
    live_wins = live.valid && (live.idx >= pend_q.idx);
    // First cycle out of reset only raises pc_valid; pc_o stays at RESET_PC.
    if (valid_q) begin
      case (state_q)
        RUN: begin
          if (bus.stall_i) begin
            if (live.valid) begin
              state_d = HOLD;
              pend_d  = live;
            end
          end else if (live.valid) begin
            load = 1'b1;
          end else if (btb_hit) begin
            load     = 1'b1;
            load_tgt = btb_tgt;
          end else begin
            pc_d = pc_q + XLEN'(STEP);
          end
        end
        HOLD: begin
          if (bus.stall_i) begin
            if (live_wins) pend_d = live;
          end else begin
            state_d  = RUN;
            pend_d   = '0;
            load     = 1'b1;
            load_tgt = live_wins ? live.target : pend_q.target;
          end
        end
        default: state_d = RUN;
      endcase
    end
    if (load) begin
      pc_d  = load_tgt & ALIGN_MASK;
      mis_d = |load_tgt[OFF-1:0];
    end
  end

  // State register; reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= '0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      mis_q   <= mis_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_valid_o   = valid_q;
  assign bus.redir_pend_o = (state_q == HOLD);
  assign bus.misalign_o   = mis_q;
  assign bus.pred_taken_o = btb_hit;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/run, redirect priority, stalled
// redirects, misalignment, wrap, and BTB behaviour (or its absence).
module tb_pc_gen;

`ifdef PC_GEN_BTB_EN
  localparam logic BTB_ON = 1'b1;
`else
  localparam logic BTB_ON = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32), .NUM_REDIR(2)) bus ();

  pc_gen #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .STEP     (4),
    .NUM_REDIR(2),
    .BTB_DEPTH(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input logic [1:0] v, input logic [31:0] t1, input logic [31:0] t0);
    bus.redir_valid_i  = v;
    bus.redir_target_i = {t1, t0};
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.stall_i          = 1'b0;
    bus.btb_upd_valid_i  = 1'b0;
    bus.btb_upd_pc_i     = '0;
    bus.btb_upd_target_i = '0;
    set_redir(2'b00, 32'h0, 32'h0);

    // Reset 2 cycles then run 3: pc 0,0,0,4,8
    exp_q = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};
    step();
    exp_v = exp_q.pop_front(); check("rst_pc0", bus.pc_o, exp_v);
    check("rst_valid0", 32'(bus.pc_valid_o), 32'h0);
    check("rst_pend", 32'(bus.redir_pend_o), 32'h0);
    check("rst_mis", 32'(bus.misalign_o), 32'h0);
    step();
    exp_v = exp_q.pop_front(); check("rst_pc1", bus.pc_o, exp_v);
    check("rst_valid1", 32'(bus.pc_valid_o), 32'h0);
    rst_n = 1'b1;
    step();
    exp_v = exp_q.pop_front(); check("run_pc0", bus.pc_o, exp_v);
    check("run_valid", 32'(bus.pc_valid_o), 32'h1);
    step();
    exp_v = exp_q.pop_front(); check("run_pc1", bus.pc_o, exp_v);
    step();
    exp_v = exp_q.pop_front(); check("run_pc2", bus.pc_o, exp_v);

    // Simultaneous redirects: channel 1 wins
    set_redir(2'b01, 32'h0, 32'h40);
    step(); check("redir_40", bus.pc_o, 32'h40);
    set_redir(2'b11, 32'h100, 32'h200);
    step(); check("both_ch1", bus.pc_o, 32'h100);
    check("both_mis", 32'(bus.misalign_o), 32'h0);
    set_redir(2'b00, 32'h0, 32'h0);
    step(); check("seq_104", bus.pc_o, 32'h104);

    // Stalled redirect latched for 3 cycles, applied on release
    bus.stall_i = 1'b1;
    set_redir(2'b01, 32'h0, 32'h80);
    step(); check("stall_pend", 32'(bus.redir_pend_o), 32'h1);
    check("stall_pc", bus.pc_o, 32'h104);
    set_redir(2'b00, 32'h0, 32'h0);
    step(); check("stall_pc2", bus.pc_o, 32'h104);
    step(); check("stall_pend3", 32'(bus.redir_pend_o), 32'h1);
    check("stall_pc3", bus.pc_o, 32'h104);
    bus.stall_i = 1'b0;
    step(); check("rel_pc", bus.pc_o, 32'h80);
    check("rel_pend", 32'(bus.redir_pend_o), 32'h0);
    step(); check("rel_seq", bus.pc_o, 32'h84);

    // HOLD priority: pending ch1 ignores later ch0
    bus.stall_i = 1'b1;
    set_redir(2'b10, 32'h300, 32'h0);
    step();
    set_redir(2'b01, 32'h0, 32'h400);
    step(); check("hold_pc", bus.pc_o, 32'h84);
    set_redir(2'b00, 32'h0, 32'h0);
    bus.stall_i = 1'b0;
    step(); check("hold_ch1_keep", bus.pc_o, 32'h300);

    // Reverse order: pending ch0 overwritten by ch1
    bus.stall_i = 1'b1;
    set_redir(2'b01, 32'h0, 32'h400);
    step();
    set_redir(2'b10, 32'h300, 32'h0);
    step();
    set_redir(2'b00, 32'h0, 32'h0);
    bus.stall_i = 1'b0;
    step(); check("hold_ch1_over", bus.pc_o, 32'h300);

    // Release with a lower-priority live redirect: pending wins
    bus.stall_i = 1'b1;
    set_redir(2'b10, 32'h500, 32'h0);
    step();
    bus.stall_i = 1'b0;
    set_redir(2'b01, 32'h0, 32'h600);
    step(); check("rel_pend_wins", bus.pc_o, 32'h500);

    // Release with a higher-priority live redirect: live wins
    bus.stall_i = 1'b1;
    set_redir(2'b01, 32'h0, 32'h700);
    step();
    bus.stall_i = 1'b0;
    set_redir(2'b10, 32'h800, 32'h0);
    step(); check("rel_live_wins", bus.pc_o, 32'h800);

    // Misaligned target
    set_redir(2'b01, 32'h0, 32'h106);
    step(); check("mis_pc", bus.pc_o, 32'h104);
    check("mis_pulse", 32'(bus.misalign_o), 32'h1);
    set_redir(2'b00, 32'h0, 32'h0);
    step(); check("mis_seq", bus.pc_o, 32'h108);
    check("mis_clear", 32'(bus.misalign_o), 32'h0);

    // Wrap
    set_redir(2'b01, 32'h0, 32'hFFFF_FFFC);
    step(); check("wrap_top", bus.pc_o, 32'hFFFF_FFFC);
    set_redir(2'b00, 32'h0, 32'h0);
    step(); check("wrap_zero", bus.pc_o, 32'h0);

    // Reset discards a pending redirect
    bus.stall_i = 1'b1;
    set_redir(2'b01, 32'h0, 32'h900);
    step(); check("pre_rst_pend", 32'(bus.redir_pend_o), 32'h1);
    rst_n       = 1'b0;
    bus.stall_i = 1'b0;
    set_redir(2'b00, 32'h0, 32'h0);
    step(); check("rst2_pc", bus.pc_o, 32'h0);
    check("rst2_pend", 32'(bus.redir_pend_o), 32'h0);
    check("rst2_valid", 32'(bus.pc_valid_o), 32'h0);
    rst_n = 1'b1;
    step(); check("rst2_hold", bus.pc_o, 32'h0);
    step(); check("rst2_seq", bus.pc_o, 32'h4);

    // BTB: record 0x10 -> 0x500
    bus.btb_upd_valid_i  = 1'b1;
    bus.btb_upd_pc_i     = 32'h10;
    bus.btb_upd_target_i = 32'h500;
    step();
    bus.btb_upd_valid_i  = 1'b0;
    step(); check("btb_pc_c", bus.pc_o, 32'hC);
    check("btb_miss_c", 32'(bus.pred_taken_o), 32'h0);
    step(); check("btb_pc_10", bus.pc_o, 32'h10);
    check("btb_hit", 32'(bus.pred_taken_o), 32'(BTB_ON));
    step(); check("btb_next", bus.pc_o, BTB_ON ? 32'h500 : 32'h14);
    check("btb_mis", 32'(bus.misalign_o), 32'h0);

    // BTB cleared by reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    check("btb_rst_pc", bus.pc_o, 32'h10);
    check("btb_rst_miss", 32'(bus.pred_taken_o), 32'h0);
    step(); check("btb_rst_seq", bus.pc_o, 32'h14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
